// File: rtl/alu_pkg.sv
// Encodings shared by the decode/issue stage, the ALU and its bench.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_REG   = 4'h0,
        OP_ANDI  = 4'h1,
        OP_ORI   = 4'h2,
        OP_XORI  = 4'h3,
        OP_SPEC  = 4'h4,
        OP_ADDI  = 4'h5,
        OP_ADDUI = 4'h6,
        OP_ADDCI = 4'h7,
        OP_SHIFT = 4'h8,
        OP_SUBI  = 4'h9,
        OP_SUBCI = 4'hA,
        OP_CMPI  = 4'hB,
        OP_BCOND = 4'hC,
        OP_MOVI  = 4'hD,
        OP_MULI  = 4'hE,
        OP_LUI   = 4'hF
    } oper_e;

    typedef enum logic [3:0] {
        F_RSV0 = 4'h0,
        F_AND  = 4'h1,
        F_OR   = 4'h2,
        F_XOR  = 4'h3,
        F_ADD  = 4'h5,
        F_ADDU = 4'h6,
        F_ADDC = 4'h7,
        F_RSV8 = 4'h8,
        F_SUB  = 4'h9,
        F_SUBC = 4'hA,
        F_CMP  = 4'hB,
        F_RSVC = 4'hC,
        F_MOV  = 4'hD,
        F_MUL  = 4'hE,
        F_TEST = 4'hF
    } rfunc_e;

    typedef enum logic [3:0] {
        S_LSHI_L  = 4'h0,
        S_LSHI_R  = 4'h1,
        S_ASHUI_L = 4'h2,
        S_ASHUI_R = 4'h3,
        S_LSH     = 4'h4,
        S_ASHU    = 4'h6
    } sfunc_e;

    typedef enum logic [3:0] {
        X_LOAD  = 4'h0,
        X_STOR  = 4'h4,
        X_JAL   = 4'h8,
        X_JCOND = 4'hC,
        X_SCOND = 4'hD
    } xfunc_e;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_HI = 4'h4, C_LS = 4'h5, C_GT = 4'h6, C_LE = 4'h7,
        C_FS = 4'h8, C_FC = 4'h9, C_LO = 4'hA, C_HS = 4'hB,
        C_LT = 4'hC, C_GE = 4'hD, C_UC = 4'hE, C_NV = 4'hF
    } cond_e;

    // Arithmetic immediates and branch displacements are signed.
    function automatic logic imm_signed(input oper_e op);
        return op inside {OP_ADDI, OP_ADDUI, OP_ADDCI, OP_SUBI,
                          OP_SUBCI, OP_CMPI, OP_MULI, OP_BCOND};
    endfunction

endpackage

// File: rtl/regfile_16x16.sv
// 16x16 register file: two combinational read ports, one clocked write port.
module regfile_16x16 #(
    parameter int NREG = 16,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DW-1:0]           rdata_a,
    output logic [DW-1:0]           rdata_b
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the ALU, with a pending-write scoreboard.
// Define WB_BYPASS_EN to forward write-back data in the accept cycle.
module decode_issue
    import alu_pkg::*;
#(
    parameter int NREG = 16,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_dst,
    output logic [DW-1:0]           out_src,
    output logic [3:0]              out_oper,
    output logic [3:0]              out_func,
    output logic [3:0]              out_cond,
    output logic [$clog2(NREG)-1:0] out_waddr,
    output logic                    out_wen,
    output logic                    out_illegal,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DW-1:0]           wb_data,
    input  logic                    flush
);

    localparam int AW = $clog2(NREG);

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    oper_e          op;
    logic [AW-1:0]  dst_reg;
    logic [3:0]     fn_fld;
    logic [AW-1:0]  src_reg;

    assign op      = oper_e'(in_instr[15:12]);
    assign dst_reg = in_instr[11:8];
    assign fn_fld  = in_instr[7:4];
    assign src_reg = in_instr[3:0];

    logic       rd_src;
    logic       wen;
    logic       illegal;
    logic [3:0] func;
    logic [3:0] cond;

    always_comb begin
        rd_src  = 1'b0;
        wen     = 1'b0;
        illegal = 1'b0;
        func    = '0;
        cond    = '0;
        unique case (op)
            OP_REG: begin
                rd_src  = 1'b1;
                func    = fn_fld;
                illegal = fn_fld inside {F_RSV0, F_RSV8, F_RSVC};
                wen     = !illegal && fn_fld != F_CMP
                          && fn_fld != F_TEST;
            end
            OP_SPEC: begin
                rd_src = 1'b1;
                func   = fn_fld;
                wen    = fn_fld inside {X_LOAD, X_JAL, X_SCOND};
                if (fn_fld == X_JCOND) begin
                    cond = dst_reg;
                end else if (fn_fld == X_SCOND) begin
                    cond = src_reg;
                end
            end
            OP_SHIFT: begin
                func   = fn_fld;
                wen    = 1'b1;
                rd_src = fn_fld inside {S_LSH, S_ASHU};
            end
            OP_BCOND: cond = dst_reg;
            OP_CMPI:  ;
            default:  wen = 1'b1;
        endcase
    end

    logic [DW-1:0] rd_raw;
    logic [DW-1:0] rs_raw;

    regfile_16x16 #(
        .NREG (NREG),
        .DW   (DW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (dst_reg),
        .raddr_b (src_reg),
        .rdata_a (rd_raw),
        .rdata_b (rs_raw)
    );

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_eff;
    logic [NREG-1:0] wb_mask;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   rs_data;

    assign wb_mask = wb_en ? onehot(wb_addr) : '0;

`ifdef WB_BYPASS_EN
    // A register retiring this cycle is already safe to read.
    assign pend_eff = pending & ~wb_mask;
    assign rd_data  = (wb_en && wb_addr == dst_reg) ? wb_data : rd_raw;
    assign rs_data  = (wb_en && wb_addr == src_reg) ? wb_data : rs_raw;
`else
    assign pend_eff = pending;
    assign rd_data  = rd_raw;
    assign rs_data  = rs_raw;
`endif

    logic hazard;
    logic accept;

    assign hazard = pend_eff[dst_reg]
                  | (rd_src & pend_eff[src_reg])
                  | (wen & pend_eff[dst_reg]);

    assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;

    logic [DW-1:0] imm;
    logic [DW-1:0] shamt;
    logic [DW-1:0] src_val;

    assign imm = imm_signed(op)
               ? {{(DW-8){in_instr[7]}}, in_instr[7:0]}
               : {{(DW-8){1'b0}}, in_instr[7:0]};
    assign shamt   = {{(DW-4){1'b0}}, src_reg};
    assign src_val = rd_src ? rs_data
                   : (op == OP_SHIFT) ? shamt : imm;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] drop_mask;

    // Set beats a same-cycle clear; a flushed writer releases its target.
    assign set_mask  = (accept & wen) ? onehot(dst_reg) : '0;
    assign drop_mask = (flush & out_valid & out_wen)
                     ? onehot(out_waddr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_mask & ~drop_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_dst     <= '0;
            out_src     <= '0;
            out_oper    <= '0;
            out_func    <= '0;
            out_cond    <= '0;
            out_waddr   <= '0;
            out_wen     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_dst     <= rd_data;
            out_src     <= src_val;
            out_oper    <= op;
            out_func    <= func;
            out_cond    <= cond;
            out_waddr   <= dst_reg;
            out_wen     <= wen;
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: directed instructions, queued expectations.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_dst;
    logic [15:0] out_src;
    logic [3:0]  out_oper;
    logic [3:0]  out_func;
    logic [3:0]  out_cond;
    logic [3:0]  out_waddr;
    logic        out_wen;
    logic        out_illegal;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        flush = 1'b0;

    decode_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dst     (out_dst),
        .out_src     (out_src),
        .out_oper    (out_oper),
        .out_func    (out_func),
        .out_cond    (out_cond),
        .out_waddr   (out_waddr),
        .out_wen     (out_wen),
        .out_illegal (out_illegal),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dst;
        logic [15:0] src;
        logic [3:0]  oper;
        logic [3:0]  func;
        logic [3:0]  cond;
        logic [3:0]  waddr;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [15:0] d, input logic [15:0] s,
                                input logic [3:0] o, input logic [3:0] f,
                                input logic [3:0] c, input logic [3:0] w,
                                input logic we, input logic il);
        exp_t e;
        e.dst = d; e.src = s; e.oper = o; e.func = f;
        e.cond = c; e.waddr = w; e.wen = we; e.ill = il;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [15:0] ins, input exp_t e,
                        input bit push, output int stall);
        @(negedge clk);
        in_instr = ins;
        in_valid = 1'b1;
        #1;
        stall = 0;
        while (!in_ready && stall < 20) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_%h: in_ready stuck at 0", ins);
        end else if (push) begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    // Monitor: every transfer to the ALU is checked against the queue head.
    initial begin
        exp_t g;
        exp_t e;
        int   nx;
        nx = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && out_ready) begin
                g = mk(out_dst, out_src, out_oper, out_func, out_cond,
                       out_waddr, out_wen, out_illegal);
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer%0d: unexpected output %h", nx, g);
                end else begin
                    e = q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL xfer%0d: got %h, expected %h",
                                 nx, g, e);
                    end
                end
                nx++;
            end
        end
    end

    initial begin
        int st;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wen", out_wen, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst_in_ready", in_ready, 1);

        // Immediate extension
        send(16'h53FE, mk(16'h0000, 16'hFFFE, 4'h5, 4'h0, 4'h0, 4'h3, 1, 0), 1, st);
        wb(4'h3, 16'h0003);
        send(16'h23FE, mk(16'h0003, 16'h00FE, 4'h2, 4'h0, 4'h0, 4'h3, 1, 0), 1, st);
        check("ori_nostall", st, 0);
        wb(4'h3, 16'h0003);

        // Back-pressure on a held movi R2
        out_ready = 1'b0;
        send(16'hD222, mk(16'h0000, 16'h0022, 4'hD, 4'h0, 4'h0, 4'h2, 1, 0), 1, st);
        @(negedge clk);
        in_instr = 16'h380F;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_src", out_src, 16'h0022);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        q.push_back(mk(16'h0000, 16'h000F, 4'h3, 4'h0, 4'h0, 4'h8, 1, 0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb(4'h2, 16'h0002);
        wb(4'h8, 16'h0008);

        // RAW: add R1,R2 then sub R4,R1
        send(16'h0152, mk(16'h0000, 16'h0002, 4'h0, 4'h5, 4'h0, 4'h1, 1, 0), 1, st);
        @(negedge clk);
        in_instr = 16'h0491;
        in_valid = 1'b1;
        #1;
        check("raw_stall_a", in_ready, 0);
        @(negedge clk);
        #1;
        check("raw_stall_b", in_ready, 0);
        wb_en   = 1'b1;
        wb_addr = 4'h1;
        wb_data = 16'h1234;
        #1;
`ifdef WB_BYPASS_EN
        check("raw_wb_ready", in_ready, 1);
        q.push_back(mk(16'h0000, 16'h1234, 4'h0, 4'h9, 4'h0, 4'h4, 1, 0));
        @(posedge clk);
        #1;
        wb_en = 1'b0;
`else
        check("raw_wb_ready", in_ready, 0);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        @(negedge clk);
        #1;
        check("raw_after_wb_ready", in_ready, 1);
        q.push_back(mk(16'h0000, 16'h1234, 4'h0, 4'h9, 4'h0, 4'h4, 1, 0));
        @(posedge clk);
        #1;
`endif
        in_valid = 1'b0;
        wb(4'h4, 16'h0004);

        // Flush a held movi R5, then cmp R5,R6 must not stall
        out_ready = 1'b0;
        send(16'hD555, mk(16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0), 0, st);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send(16'h05B6, mk(16'h0000, 16'h0000, 4'h0, 4'hB, 4'h0, 4'h5, 0, 0), 1, st);
        check("cmp_nostall", st, 0);

        // Reserved func, cmpi, shifts, branches, lui
        send(16'h0783, mk(16'h0000, 16'h0003, 4'h0, 4'h8, 4'h0, 4'h7, 0, 1), 1, st);
        send(16'h09D7, mk(16'h0000, 16'h0000, 4'h0, 4'hD, 4'h0, 4'h9, 1, 0), 1, st);
        check("illegal_nopend", st, 0);
        send(16'hB3F0, mk(16'h0003, 16'hFFF0, 4'hB, 4'h0, 4'h0, 4'h3, 0, 0), 1, st);
        send(16'h8305, mk(16'h0003, 16'h0005, 4'h8, 4'h0, 4'h0, 4'h3, 1, 0), 1, st);
        wb(4'h9, 16'h0009);
        wb(4'h3, 16'h0003);
        send(16'hC180, mk(16'h1234, 16'hFF80, 4'hC, 4'h0, 4'h1, 4'h1, 0, 0), 1, st);
        send(16'h4EC2, mk(16'h0000, 16'h0002, 4'h4, 4'hC, 4'hE, 4'hE, 0, 0), 1, st);
        send(16'hFA12, mk(16'h0000, 16'h0012, 4'hF, 4'h0, 4'h0, 4'hA, 1, 0), 1, st);
        send(16'h8342, mk(16'h0003, 16'h0002, 4'h8, 4'h4, 4'h0, 4'h3, 1, 0), 1, st);
        wb(4'h3, 16'h0003);
        wb(4'hA, 16'h1200);

        // Asynchronous reset with a held instruction and mask 0x00F0
        send(16'hD444, mk(16'h0004, 16'h0044, 4'hD, 4'h0, 4'h0, 4'h4, 1, 0), 1, st);
        send(16'hD555, mk(16'h0000, 16'h0055, 4'hD, 4'h0, 4'h0, 4'h5, 1, 0), 1, st);
        send(16'hD666, mk(16'h0000, 16'h0066, 4'hD, 4'h0, 4'h0, 4'h6, 1, 0), 1, st);
        send(16'hD777, mk(16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0), 0, st);
        out_ready = 1'b0;
        #1;
        check("pre_rst_mask", dut.pending, 16'h00F0);
        check("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_mask", dut.pending, 0);
        check("arst_out_src", out_src, 0);
        check("arst_out_waddr", out_waddr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0053, mk(16'h0000, 16'h0000, 4'h0, 4'h5, 4'h0, 4'h0, 1, 0), 1, st);
        check("post_rst_nostall", st, 0);

        repeat (3) @(negedge clk);
        #4;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
